wt_dcache_rd_arb: RTL and testbench
===================================

WT_DCACHE_RD_ARB -- requirements
Module: wt_dcache_rd_arb

Interface
REQ-001 SHALL have parameter NumPorts, default 3, meaning the number of read requesters (2..8).
REQ-002 SHALL have parameter MemAckLat, default 1, meaning the cycles from mem_rd_ack_i to valid mem_rd_data_i / hit / valid bits; only 1 is supported.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port rd_req_i, input, NumPorts, per-port read request.
REQ-006 SHALL have port rd_tag_i, input, NumPorts x DCACHE_TAG_WIDTH, per-port tag, valid one cycle after that port's ack.
REQ-007 SHALL have port rd_idx_i, input, NumPorts x DCACHE_CL_IDX_WIDTH, per-port index.
REQ-008 SHALL have port rd_off_i, input, NumPorts x DCACHE_OFFSET_WIDTH, per-port offset.
REQ-009 SHALL have port rd_tag_only_i, input, NumPorts, per-port tag-only flag.
REQ-010 SHALL have port rd_ack_o, output, NumPorts, per-port grant/ack; at most one bit set.
REQ-011 SHALL have port rd_rvalid_o, output, NumPorts, one-hot marker that the response belongs to this port.
REQ-012 SHALL have port rd_data_o, output, riscv::xlen_t, data broadcast to all ports.
REQ-013 SHALL have port rd_user_o, output, DCACHE_USER_WIDTH, user bits broadcast to all ports.
REQ-014 SHALL have port rd_vld_bits_o, output, DCACHE_SET_ASSOC, valid bits broadcast to all ports.
REQ-015 SHALL have port rd_hit_oh_o, output, DCACHE_SET_ASSOC, hit vector broadcast to all ports.
REQ-016 SHALL have port mem_rd_req_o, output, 1, request to the cache memory.
REQ-017 SHALL have ports mem_rd_tag_o, mem_rd_idx_o, mem_rd_off_o and mem_rd_tag_only_o, outputs, package widths, forwarded request fields.
REQ-018 SHALL have port mem_rd_ack_i, input, 1, memory accepted the read this cycle.
REQ-019 SHALL have ports mem_rd_data_i, mem_rd_user_i, mem_rd_vld_bits_i and mem_rd_hit_oh_i, inputs, package widths, memory response.

Function
REQ-020 SHALL select the winner sel = the first requesting port at or after rr_ptr, in round-robin order with wrap from NumPorts-1 to 0.
REQ-021 SHALL drive mem_rd_req_o = |rd_req_i, and forward rd_idx_i, rd_off_i and rd_tag_only_i of sel combinationally.
REQ-022 SHALL drive rd_ack_o[sel] = mem_rd_ack_i & rd_req_i[sel]; all other bits SHALL be 0.
REQ-023 Lock: if sel requests and mem_rd_ack_i=0, lock_q SHALL set with lock_idx_q=sel.
REQ-024 While lock_q=1, sel SHALL equal lock_idx_q regardless of rr_ptr.
REQ-025 lock_q SHALL clear on ack of the locked port or when the locked port deasserts rd_req_i.
REQ-026 On ack, rr_ptr SHALL become (sel+1) mod NumPorts.
REQ-027 On no ack, rr_ptr SHALL hold.
REQ-028 On ack in cycle N, ack_q SHALL be 1 and ack_idx_q SHALL be sel in cycle N+1.
REQ-029 mem_rd_tag_o SHALL equal rd_tag_i[ack_idx_q] whenever ack_q=1.
REQ-030 mem_rd_tag_o SHALL equal rd_tag_i[sel] whenever ack_q=0.
REQ-031 rd_rvalid_o SHALL be onehot(ack_idx_q) when ack_q=1 and 0 otherwise, aligned with the mem response.
REQ-032 rd_data_o, rd_user_o, rd_vld_bits_o and rd_hit_oh_o SHALL be pure pass-throughs of the mem inputs; there is no storage.
REQ-033 Back-to-back acks of different ports SHALL be sustained at 1 per cycle.
REQ-034 The tag of port A (cycle N+1) and the request of port B (cycle N+1) SHALL coexist: mem_rd_tag_o carries A's tag, and idx/off carry B.
REQ-035 A single requester SHALL be granted every cycle that mem_rd_ack_i=1, with no idle bubble.
REQ-036 A requester dropping rd_req_i without ack SHALL leave no state except that lock_q clears.
REQ-037 NumPorts not a power of two: rr_ptr SHALL never exceed NumPorts-1.

Reset
REQ-038 On rst_ni=0 at a clk_i edge: rr_ptr=0, lock_q=0, lock_idx_q=0, ack_q=0, ack_idx_q=0.
REQ-039 During reset: rd_ack_o=0, rd_rvalid_o=0, and mem_rd_req_o follows rd_req_i (it is combinational).
REQ-040 Reset asserted mid-transaction SHALL discard the pending rvalid; the cycle after reset, rd_rvalid_o=0 even if an ack occurred in the prior cycle.

Verification
REQ-041 NumPorts=3, rd_req_i=3'b111, mem_rd_ack_i=1 for 6 cycles -> rd_ack_o sequence 001,010,100,001,010,100; rd_rvalid_o is the same sequence delayed by 1.
REQ-042 rd_req_i=3'b011, mem_rd_ack_i=0 for 3 cycles then 1 -> rd_ack_o stays 0 and sel stays port 0 (locked); port 0 is acked in cycle 4, then port 1 in cycle 5.
REQ-043 Port 0 acked with rd_tag_i[0]=0xAAA next cycle while port 2 requests with rd_idx_i[2]=5 -> mem_rd_tag_o=0xAAA and mem_rd_idx_o=5 in the same cycle.
REQ-044 Locked port 1 drops rd_req_i with no ack while port 2 requests -> next cycle sel=2, and lock clears.
REQ-045 Ack in cycle N, rst_ni=0 in cycle N+1 -> rd_rvalid_o=0 in N+1 and N+2; rr_ptr=0 after reset.
REQ-046 Only port 2 requests with mem_rd_ack_i=1 for 4 cycles -> 4 acks to port 2, 4 consecutive rvalids, and rr_ptr=0 after each ack.

Source files
------------

// File: rtl/wt_dcache_rd_arb.sv
// Round-robin read arbiter in front of the data cache memory: one requester per cycle,
// request fields forwarded combinationally, the response steered back by a one-hot rvalid.
module wt_dcache_rd_arb #(
    parameter int unsigned NumPorts          = 3,
    parameter int unsigned MemAckLat         = 1,
    parameter int unsigned Xlen              = 64,
    parameter int unsigned DcacheTagWidth    = 16,
    parameter int unsigned DcacheClIdxWidth  = 8,
    parameter int unsigned DcacheOffsetWidth = 4,
    parameter int unsigned DcacheUserWidth   = 1,
    parameter int unsigned DcacheSetAssoc    = 8
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_ni,
    input  logic [NumPorts-1:0]                                  rd_req_i,
    input  logic [NumPorts-1:0][DcacheTagWidth-1:0]              rd_tag_i,
    input  logic [NumPorts-1:0][DcacheClIdxWidth-1:0]            rd_idx_i,
    input  logic [NumPorts-1:0][DcacheOffsetWidth-1:0]           rd_off_i,
    input  logic [NumPorts-1:0]                                  rd_tag_only_i,
    output logic [NumPorts-1:0]                                  rd_ack_o,
    output logic [NumPorts-1:0]                                  rd_rvalid_o,
    output logic [Xlen-1:0]                                      rd_data_o,
    output logic [DcacheUserWidth-1:0]                           rd_user_o,
    output logic [DcacheSetAssoc-1:0]                            rd_vld_bits_o,
    output logic [DcacheSetAssoc-1:0]                            rd_hit_oh_o,
    output logic                                                 mem_rd_req_o,
    output logic [DcacheTagWidth-1:0]                            mem_rd_tag_o,
    output logic [DcacheClIdxWidth-1:0]                          mem_rd_idx_o,
    output logic [DcacheOffsetWidth-1:0]                         mem_rd_off_o,
    output logic                                                 mem_rd_tag_only_o,
    input  logic                                                 mem_rd_ack_i,
    input  logic [Xlen-1:0]                                      mem_rd_data_i,
    input  logic [DcacheUserWidth-1:0]                           mem_rd_user_i,
    input  logic [DcacheSetAssoc-1:0]                            mem_rd_vld_bits_i,
    input  logic [DcacheSetAssoc-1:0]                            mem_rd_hit_oh_i
);
    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [PtrW-1:0] r_rr_ptr;
    logic [PtrW-1:0] r_lock_idx;
    logic [PtrW-1:0] r_ack_idx;
    logic            r_lock;
    logic            r_ack;

    logic [PtrW-1:0] w_rr_sel;
    logic [PtrW-1:0] w_sel;
    logic [PtrW-1:0] w_rr_next;
    logic            w_gnt;
    logic            w_rsp_vld;

    // Scan downward so the requester closest to the pointer is the last one written.
    always_comb begin : p_rr_pick
        logic [PtrW:0] w_cand;
        w_rr_sel = r_rr_ptr;
        w_cand   = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            w_cand = {1'b0, r_rr_ptr} + (PtrW+1)'(i);
            if (w_cand >= (PtrW+1)'(NumPorts)) begin
                w_cand = w_cand - (PtrW+1)'(NumPorts);
            end
            if (rd_req_i[w_cand[PtrW-1:0]]) begin
                w_rr_sel = w_cand[PtrW-1:0];
            end
        end
    end

    assign w_sel     = r_lock ? r_lock_idx : w_rr_sel;
    assign w_gnt     = rst_ni & mem_rd_ack_i & rd_req_i[w_sel];
    assign w_rr_next = (w_sel == PtrW'(NumPorts - 1)) ? '0 : w_sel + 1'b1;
    // Only the single-cycle memory latency is supported; any other setting never signals a response.
    assign w_rsp_vld = r_ack & rst_ni & (MemAckLat == 1);

    assign mem_rd_req_o      = |rd_req_i;
    assign mem_rd_idx_o      = rd_idx_i[w_sel];
    assign mem_rd_off_o      = rd_off_i[w_sel];
    assign mem_rd_tag_only_o = rd_tag_only_i[w_sel];
    // The tag arrives one cycle after the grant, so it follows the previous winner.
    assign mem_rd_tag_o      = r_ack ? rd_tag_i[r_ack_idx] : rd_tag_i[w_sel];

    generate
        for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
            assign rd_ack_o[gi]    = w_gnt & (w_sel == PtrW'(gi));
            assign rd_rvalid_o[gi] = w_rsp_vld & (r_ack_idx == PtrW'(gi));
        end
    endgenerate

    assign rd_data_o     = mem_rd_data_i;
    assign rd_user_o     = mem_rd_user_i;
    assign rd_vld_bits_o = mem_rd_vld_bits_i;
    assign rd_hit_oh_o   = mem_rd_hit_oh_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_ack      <= 1'b0;
            r_ack_idx  <= '0;
        end else begin
            if (w_gnt) begin
                r_rr_ptr  <= w_rr_next;
                r_ack_idx <= w_sel;
            end
            // Holds while the winner waits; drops on its grant or when it withdraws.
            r_lock     <= rd_req_i[w_sel] & ~mem_rd_ack_i;
            r_lock_idx <= w_sel;
            r_ack      <= w_gnt;
        end
    end

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Scoreboard bench for wt_dcache_rd_arb: directed scenarios followed by randomized traffic,
// expectations from a queue-free behavioural model of the round-robin/lock rules.
module tb_wt_dcache_rd_arb;
    localparam int NP = 3;
    localparam int TW = 16;
    localparam int IW = 8;
    localparam int OW = 4;
    localparam int XL = 64;
    localparam int UW = 1;
    localparam int SA = 8;

    logic                   clk;
    logic                   rst_n;
    logic [NP-1:0]          rd_req;
    logic [NP-1:0][TW-1:0]  rd_tag;
    logic [NP-1:0][IW-1:0]  rd_idx;
    logic [NP-1:0][OW-1:0]  rd_off;
    logic [NP-1:0]          rd_tag_only;
    logic [NP-1:0]          rd_ack;
    logic [NP-1:0]          rd_rvalid;
    logic [XL-1:0]          rd_data;
    logic [UW-1:0]          rd_user;
    logic [SA-1:0]          rd_vld_bits;
    logic [SA-1:0]          rd_hit_oh;
    logic                   mem_req;
    logic [TW-1:0]          mem_tag;
    logic [IW-1:0]          mem_idx;
    logic [OW-1:0]          mem_off;
    logic                   mem_tag_only;
    logic                   mem_ack;
    logic [XL-1:0]          mem_data;
    logic [UW-1:0]          mem_user;
    logic [SA-1:0]          mem_vld;
    logic [SA-1:0]          mem_hit;

    wt_dcache_rd_arb #(
        .NumPorts(NP), .MemAckLat(1), .Xlen(XL), .DcacheTagWidth(TW),
        .DcacheClIdxWidth(IW), .DcacheOffsetWidth(OW), .DcacheUserWidth(UW), .DcacheSetAssoc(SA)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rd_req_i(rd_req), .rd_tag_i(rd_tag), .rd_idx_i(rd_idx), .rd_off_i(rd_off),
        .rd_tag_only_i(rd_tag_only), .rd_ack_o(rd_ack), .rd_rvalid_o(rd_rvalid),
        .rd_data_o(rd_data), .rd_user_o(rd_user), .rd_vld_bits_o(rd_vld_bits), .rd_hit_oh_o(rd_hit_oh),
        .mem_rd_req_o(mem_req), .mem_rd_tag_o(mem_tag), .mem_rd_idx_o(mem_idx), .mem_rd_off_o(mem_off),
        .mem_rd_tag_only_o(mem_tag_only), .mem_rd_ack_i(mem_ack), .mem_rd_data_i(mem_data),
        .mem_rd_user_i(mem_user), .mem_rd_vld_bits_i(mem_vld), .mem_rd_hit_oh_i(mem_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP-1:0] ack;
        logic [NP-1:0] rvalid;
        logic          req;
        logic [TW-1:0] tag;
        logic [IW-1:0] idx;
        logic [OW-1:0] off;
        logic          tonly;
        logic [XL-1:0] data;
        logic [UW-1:0] user;
        logic [SA-1:0] vld;
        logic [SA-1:0] hit;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model state: pointer, lock, and the grant awaiting its response.
    int   m_rr     = 0;
    bit   m_locked = 1'b0;
    int   m_lport  = 0;
    bit   m_pend   = 1'b0;
    int   m_pport  = 0;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic rand_fields();
        for (int p = 0; p < NP; p++) begin
            rd_tag[p]      = TW'($urandom);
            rd_idx[p]      = IW'($urandom);
            rd_off[p]      = OW'($urandom);
            rd_tag_only[p] = 1'($urandom_range(0, 1));
        end
        mem_data = {$urandom, $urandom};
        mem_user = UW'($urandom);
        mem_vld  = SA'($urandom);
        mem_hit  = SA'($urandom);
    endtask

    task automatic slot(input logic r, input logic [NP-1:0] rq, input logic ma);
        @(posedge clk);
        #1;
        cyc++;
        rand_fields();
        rst_n   = r;
        rd_req  = rq;
        mem_ack = ma;
    endtask

    task automatic model_push();
        exp_t e;
        int   sel;
        bit   gnt;
        if (m_locked) begin
            sel = m_lport;
        end else begin
            sel = m_rr;
            for (int k = 0; k < NP; k++) begin
                if (rd_req[(m_rr + k) % NP]) begin
                    sel = (m_rr + k) % NP;
                    break;
                end
            end
        end
        gnt      = rst_n && rd_req[sel] && mem_ack;
        e.ack    = '0;
        if (gnt) e.ack[sel] = 1'b1;
        e.rvalid = '0;
        if (rst_n && m_pend) e.rvalid[m_pport] = 1'b1;
        e.req    = |rd_req;
        e.tag    = m_pend ? rd_tag[m_pport] : rd_tag[sel];
        e.idx    = rd_idx[sel];
        e.off    = rd_off[sel];
        e.tonly  = rd_tag_only[sel];
        e.data   = mem_data;
        e.user   = mem_user;
        e.vld    = mem_vld;
        e.hit    = mem_hit;
        sb.push_back(e);
        if (!rst_n) begin
            m_rr = 0; m_locked = 1'b0; m_lport = 0; m_pend = 1'b0; m_pport = 0;
        end else begin
            if (m_locked && (gnt || !rd_req[m_lport])) m_locked = 1'b0;
            if (rd_req[sel] && !mem_ack) begin
                m_locked = 1'b1;
                m_lport  = sel;
            end
            if (gnt) begin
                m_rr    = (sel + 1) % NP;
                m_pport = sel;
            end
            m_pend = gnt;
        end
    endtask

    task automatic step(input logic r, input logic [NP-1:0] rq, input logic ma);
        slot(r, rq, ma);
        model_push();
    endtask

    // Monitor: one scoreboard entry per cycle, response fields checked when a port is marked valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("rd_ack", 128'(rd_ack), 128'(e.ack));
                check("rd_rvalid", 128'(rd_rvalid), 128'(e.rvalid));
                check("mem_req", 128'(mem_req), 128'(e.req));
                check("mem_tag", 128'(mem_tag), 128'(e.tag));
                check("mem_idx", 128'(mem_idx), 128'(e.idx));
                check("mem_off", 128'(mem_off), 128'(e.off));
                check("mem_tag_only", 128'(mem_tag_only), 128'(e.tonly));
                if (e.rvalid != '0) begin
                    check("rd_data", 128'(rd_data), 128'(e.data));
                    check("rd_user", 128'(rd_user), 128'(e.user));
                    check("rd_vld_bits", 128'(rd_vld_bits), 128'(e.vld));
                    check("rd_hit_oh", 128'(rd_hit_oh), 128'(e.hit));
                    $display("rsp cyc=%0d port_mask=%b data=%h", cyc, rd_rvalid, rd_data);
                end
            end
        end
    end

    initial begin
        logic [NP-1:0] rq;
        rst_n   = 1'b0;
        rd_req  = '0;
        mem_ack = 1'b0;
        rand_fields();

        step(1'b0, 3'b000, 1'b0);
        step(1'b0, 3'b000, 1'b0);

        // Full-load rotation 001,010,100,...
        repeat (6) step(1'b1, 3'b111, 1'b1);
        step(1'b1, 3'b000, 1'b0);

        // Lock on port 0 while memory stalls, then 0 then 1.
        step(1'b0, 3'b000, 1'b0);
        repeat (3) step(1'b1, 3'b011, 1'b0);
        step(1'b1, 3'b011, 1'b1);
        step(1'b1, 3'b011, 1'b1);

        // Tag of the previous winner coexists with the next winner's index.
        step(1'b0, 3'b000, 1'b0);
        step(1'b1, 3'b101, 1'b1);
        slot(1'b1, 3'b100, 1'b1);
        rd_tag[0] = TW'(16'h0AAA);
        rd_idx[2] = IW'(5);
        model_push();

        // Locked port 1 withdraws; port 2 wins the following cycle.
        step(1'b0, 3'b000, 1'b0);
        step(1'b1, 3'b010, 1'b0);
        step(1'b1, 3'b100, 1'b0);
        step(1'b1, 3'b100, 1'b1);

        // Reset straight after a grant discards the response.
        step(1'b1, 3'b111, 1'b1);
        step(1'b0, 3'b111, 1'b1);
        step(1'b0, 3'b000, 1'b0);
        step(1'b1, 3'b111, 1'b1);

        // Single requester on the last port, granted back to back.
        step(1'b0, 3'b000, 1'b0);
        repeat (4) step(1'b1, 3'b100, 1'b1);
        step(1'b1, 3'b010, 1'b1);

        // Randomized traffic with sticky requests so locks form and break.
        rq = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (rq[p]) rq[p] = ($urandom_range(0, 9) < 8);
                else       rq[p] = ($urandom_range(0, 9) < 4);
            end
            step(($urandom_range(0, 59) != 0), rq, ($urandom_range(0, 3) != 0));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain cyc=%0d got=%0d exp=0", cyc, sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
